alu_arbiter: RTL and testbench

- Shares one combinational ALU instance between two requesters: req0 (core pipeline) and req1 (address/auxiliary unit).
- Round-robin arbitration with valid/ready handshakes on both request channels and on the single response channel.
- One registered result slot.
- MUL is a multi-cycle operation (MUL_CYCLES) so the ALU path is never closed through a full 32x32 multiply in one cycle.

---
 rtl/alu_pkg.sv | 30 +++
 rtl/alu_arbiter_alu.sv | 32 +++
 rtl/alu_arbiter.sv | 159 +++++++++++++++
 tb/tb_alu_arbiter.sv | 209 ++++++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// Shared definitions for the arbitrated ALU slice.
// Contents: the nine legal ALU control codes, the legality check used by the
// arbiter to mask results, and the 2-bit arbiter FSM state encoding.
package alu_pkg;

  localparam logic [3:0] OP_AND = 4'b0000;
  localparam logic [3:0] OP_OR  = 4'b0001;
  localparam logic [3:0] OP_SLL = 4'b0011;
  localparam logic [3:0] OP_SUB = 4'b0100;
  localparam logic [3:0] OP_SRL = 4'b0101;
  localparam logic [3:0] OP_MUL = 4'b0110;
  localparam logic [3:0] OP_XOR = 4'b0111;
  localparam logic [3:0] OP_SLT = 4'b1000;
  localparam logic [3:0] OP_ADD = 4'b1111;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_MUL_WAIT = 2'd1,
    ST_RESP     = 2'd2
  } state_t;

  function automatic logic is_legal_op(input logic [3:0] op);
    case (op)
      OP_AND, OP_OR, OP_SLL, OP_SUB, OP_SRL,
      OP_MUL, OP_XOR, OP_SLT, OP_ADD: is_legal_op = 1'b1;
      default:                        is_legal_op = 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/alu_arbiter_alu.sv
// Combinational 32-bit ALU shared by both requesters.
// Ports:
//   in1, in2 : operands (unsigned)
//   op       : ALU control code (see alu_pkg)
//   result   : ALU result; 0 for unknown codes
// Arithmetic wraps modulo 2^32; shifts use in2[4:0] only; SLT is unsigned.
module alu_arbiter_alu
  import alu_pkg::*;
(
  input  logic [31:0] in1,
  input  logic [31:0] in2,
  input  logic [3:0]  op,
  output logic [31:0] result
);

  always_comb begin
    result = 32'd0;
    case (op)
      OP_AND: result = in1 & in2;
      OP_OR:  result = in1 | in2;
      OP_ADD: result = in1 + in2;
      OP_SUB: result = in1 - in2;
      OP_SLT: result = {31'd0, (in1 < in2)};
      OP_SLL: result = in1 << in2[4:0];
      OP_SRL: result = in1 >> in2[4:0];
      OP_MUL: result = in1 * in2;
      OP_XOR: result = in1 ^ in2;
      default: result = 32'd0;
    endcase
  end

endmodule

// File: rtl/alu_arbiter.sv
// Round-robin arbiter sharing one ALU between two requesters, with a single
// registered result slot and a multi-cycle MUL.
// Ports:
//   clk, reset                   : clock (rising edge), synchronous active-high reset
//   reqN_valid/ready/in1/in2/op  : request channel N (N = 0 core, 1 aux)
//   rsp_valid/ready              : response channel handshake
//   rsp_id                       : requester that issued the held result
//   rsp_result, rsp_zero         : ALU result and its zero flag
//   rsp_illegal                  : held result came from an unknown op code
//
// Handshake: a transfer happens on a rising edge where valid and ready are
// both high. Producers hold valid and payload stable until that edge and never
// withdraw valid. reqN_ready is combinational from state and valids; at most
// one of them is high in any cycle. rsp_* stay stable while rsp_valid is high
// and rsp_ready is low.
module alu_arbiter
  import alu_pkg::*;
#(
  parameter int unsigned MUL_CYCLES = 3
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req0_valid,
  output logic        req0_ready,
  input  logic [31:0] req0_in1,
  input  logic [31:0] req0_in2,
  input  logic [3:0]  req0_op,
  input  logic        req1_valid,
  output logic        req1_ready,
  input  logic [31:0] req1_in1,
  input  logic [31:0] req1_in2,
  input  logic [3:0]  req1_op,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic        rsp_id,
  output logic [31:0] rsp_result,
  output logic        rsp_zero,
  output logic        rsp_illegal
);

  // With a single-cycle MUL the multiply goes through the normal capture path.
  localparam bit MUL_MULTI = (MUL_CYCLES > 1);
  localparam logic [3:0] MUL_LOAD = 4'(MUL_CYCLES - 1);

  state_t      state;
  logic        last_grant;
  logic [3:0]  mul_cnt;
  logic [31:0] mul_a;
  logic [31:0] mul_b;
  logic [3:0]  mul_op;
  logic        mul_id;

  logic        can_accept;
  logic        gnt0;
  logic        gnt1;
  logic [31:0] alu_a;
  logic [31:0] alu_b;
  logic [3:0]  alu_op;
  logic [31:0] alu_y;
  logic        op_legal;
  logic        start_mul;

  assign can_accept = (state == ST_IDLE) || ((state == ST_RESP) && rsp_ready);

  // On a tie the requester that did not win last time gets the grant.
  assign gnt0 = can_accept && req0_valid && (!req1_valid || last_grant);
  assign gnt1 = can_accept && req1_valid && (!req0_valid || !last_grant);

  assign req0_ready = gnt0;
  assign req1_ready = gnt1;

  // While a MUL is in flight the ALU sees the latched operands, otherwise the
  // currently granted request.
  always_comb begin
    alu_a  = req0_in1;
    alu_b  = req0_in2;
    alu_op = req0_op;
    if (state == ST_MUL_WAIT) begin
      alu_a  = mul_a;
      alu_b  = mul_b;
      alu_op = mul_op;
    end else if (gnt1) begin
      alu_a  = req1_in1;
      alu_b  = req1_in2;
      alu_op = req1_op;
    end
  end

  assign op_legal  = is_legal_op(alu_op);
  assign start_mul = MUL_MULTI && (alu_op == OP_MUL);

  alu_arbiter_alu u_alu (
    .in1    (alu_a),
    .in2    (alu_b),
    .op     (alu_op),
    .result (alu_y)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= ST_IDLE;
      last_grant  <= 1'b1;
      mul_cnt     <= 4'd0;
      mul_a       <= 32'd0;
      mul_b       <= 32'd0;
      mul_op      <= 4'd0;
      mul_id      <= 1'b0;
      rsp_valid   <= 1'b0;
      rsp_id      <= 1'b0;
      rsp_result  <= 32'd0;
      rsp_zero    <= 1'b0;
      rsp_illegal <= 1'b0;
    end else begin
      case (state)
        ST_MUL_WAIT: begin
          if (mul_cnt == 4'd1) begin
            state       <= ST_RESP;
            mul_cnt     <= 4'd0;
            rsp_valid   <= 1'b1;
            rsp_id      <= mul_id;
            rsp_result  <= alu_y;
            rsp_zero    <= (alu_y == 32'd0);
            rsp_illegal <= 1'b0;
          end else begin
            mul_cnt <= mul_cnt - 4'd1;
          end
        end
        default: begin
          // ST_IDLE, or ST_RESP being drained; a stalled ST_RESP holds.
          if (can_accept) begin
            if (gnt0 || gnt1) begin
              last_grant <= gnt1;
              if (start_mul) begin
                state     <= ST_MUL_WAIT;
                mul_cnt   <= MUL_LOAD;
                mul_a     <= alu_a;
                mul_b     <= alu_b;
                mul_op    <= alu_op;
                mul_id    <= gnt1;
                rsp_valid <= 1'b0;
              end else begin
                state       <= ST_RESP;
                rsp_valid   <= 1'b1;
                rsp_id      <= gnt1;
                rsp_result  <= op_legal ? alu_y : 32'd0;
                rsp_zero    <= op_legal && (alu_y == 32'd0);
                rsp_illegal <= !op_legal;
              end
            end else begin
              state     <= ST_IDLE;
              rsp_valid <= 1'b0;
            end
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_alu_arbiter.sv
// Directed bench for alu_arbiter (MUL_CYCLES = 3) with hand-computed results.
module tb_alu_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  logic        req0_valid, req0_ready;
  logic [31:0] req0_in1, req0_in2;
  logic [3:0]  req0_op;
  logic        req1_valid, req1_ready;
  logic [31:0] req1_in1, req1_in2;
  logic [3:0]  req1_op;
  logic        rsp_valid, rsp_ready, rsp_id;
  logic [31:0] rsp_result;
  logic        rsp_zero, rsp_illegal;

  int checks = 0;
  int errors = 0;

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  alu_arbiter #(.MUL_CYCLES(3)) dut (
    .clk         (clk),
    .reset       (reset),
    .req0_valid  (req0_valid),
    .req0_ready  (req0_ready),
    .req0_in1    (req0_in1),
    .req0_in2    (req0_in2),
    .req0_op     (req0_op),
    .req1_valid  (req1_valid),
    .req1_ready  (req1_ready),
    .req1_in1    (req1_in1),
    .req1_in2    (req1_in2),
    .req1_op     (req1_op),
    .rsp_valid   (rsp_valid),
    .rsp_ready   (rsp_ready),
    .rsp_id      (rsp_id),
    .rsp_result  (rsp_result),
    .rsp_zero    (rsp_zero),
    .rsp_illegal (rsp_illegal)
  );

  // ---------------- scoreboard ----------------
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=0x%08h exp=0x%08h", tag, got, exp);
    end
  endtask

  // ---------------- driver tasks ----------------
  // Advance one edge and settle outputs before sampling.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;
  endtask

  task automatic drive0(input logic [31:0] a, input logic [31:0] b, input logic [3:0] op);
    req0_in1 = a; req0_in2 = b; req0_op = op; req0_valid = 1'b1;
  endtask

  task automatic drive1(input logic [31:0] a, input logic [31:0] b, input logic [3:0] op);
    req1_in1 = a; req1_in2 = b; req1_op = op; req1_valid = 1'b1;
  endtask

  // Single non-MUL op on requester 0 with rsp_ready high; checks grant then slot.
  task automatic op0(input string tag, input logic [31:0] a, input logic [31:0] b,
                     input logic [3:0] op, input logic [31:0] exp_res,
                     input logic exp_zero, input logic exp_ill);
    drive0(a, b, op);
    #1;
    check({tag, "_ready"}, 32'(req0_ready), 32'd1);
    tick();
    req0_valid = 1'b0;
    check({tag, "_valid"}, 32'(rsp_valid), 32'd1);
    check({tag, "_result"}, rsp_result, exp_res);
    check({tag, "_zero"}, 32'(rsp_zero), 32'(exp_zero));
    check({tag, "_illegal"}, 32'(rsp_illegal), 32'(exp_ill));
  endtask

  initial begin
    reset = 1'b1; rsp_ready = 1'b1;
    req0_valid = 1'b0; req0_in1 = '0; req0_in2 = '0; req0_op = '0;
    req1_valid = 1'b0; req1_in1 = '0; req1_in2 = '0; req1_op = '0;

    // ---- reset state ----
    do_reset();
    check("rst_valid", 32'(rsp_valid), 32'd0);
    check("rst_id", 32'(rsp_id), 32'd0);
    check("rst_result", rsp_result, 32'd0);
    check("rst_zero", 32'(rsp_zero), 32'd0);
    check("rst_illegal", 32'(rsp_illegal), 32'd0);
    check("rst_ready0", 32'(req0_ready), 32'd0);

    // ---- single op: ADD wraps into bit 31 ----
    op0("add", 32'h7FFF_FFFF, 32'h1, 4'b1111, 32'h8000_0000, 1'b0, 1'b0);
    check("add_id", 32'(rsp_id), 32'd0);
    tick();
    check("add_drain", 32'(rsp_valid), 32'd0);

    // ---- contention: strict alternation starting with req0 ----
    do_reset();
    drive0(32'd5, 32'd5, 4'b0100);
    drive1(32'h0000_F0F0, 32'h0000_0F0F, 4'b0111);
    for (int i = 0; i < 4; i++) begin
      #1;
      check("cont_ready0", 32'(req0_ready), (i % 2 == 0) ? 32'd1 : 32'd0);
      check("cont_ready1", 32'(req1_ready), (i % 2 == 0) ? 32'd0 : 32'd1);
      tick();
      check("cont_valid", 32'(rsp_valid), 32'd1);
      check("cont_id", 32'(rsp_id), (i % 2 == 0) ? 32'd0 : 32'd1);
      check("cont_result", rsp_result, (i % 2 == 0) ? 32'd0 : 32'h0000_FFFF);
      check("cont_zero", 32'(rsp_zero), (i % 2 == 0) ? 32'd1 : 32'd0);
    end

    // ---- backpressure: slot holds req1's XOR, no grants ----
    rsp_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      #1;
      check("bp_ready0", 32'(req0_ready), 32'd0);
      check("bp_ready1", 32'(req1_ready), 32'd0);
      tick();
      check("bp_valid", 32'(rsp_valid), 32'd1);
      check("bp_id", 32'(rsp_id), 32'd1);
      check("bp_result", rsp_result, 32'h0000_FFFF);
    end
    rsp_ready = 1'b1;
    #1;
    check("bp_release_ready0", 32'(req0_ready), 32'd1);
    check("bp_release_ready1", 32'(req1_ready), 32'd0);
    tick();
    check("bp_release_id", 32'(rsp_id), 32'd0);
    check("bp_release_result", rsp_result, 32'd0);
    req0_valid = 1'b0; req1_valid = 1'b0;
    tick();
    check("bp_drain", 32'(rsp_valid), 32'd0);

    // ---- MUL on req1 (last grant was 0 so req1 wins); req0 held off ----
    drive0(32'h0000_00FF, 32'h0000_000F, 4'b0000);
    drive1(32'h0001_0000, 32'h0001_0001, 4'b0110);
    #1;
    check("mul_ready1", 32'(req1_ready), 32'd1);
    check("mul_ready0", 32'(req0_ready), 32'd0);
    tick();
    req1_valid = 1'b0;
    for (int i = 0; i < 2; i++) begin
      check("mul_wait_valid", 32'(rsp_valid), 32'd0);
      check("mul_wait_ready0", 32'(req0_ready), 32'd0);
      tick();
    end
    check("mul_valid", 32'(rsp_valid), 32'd1);
    check("mul_id", 32'(rsp_id), 32'd1);
    check("mul_result", rsp_result, 32'h0001_0000);
    check("mul_next_ready0", 32'(req0_ready), 32'd1);
    tick();
    req0_valid = 1'b0;
    check("and_id", 32'(rsp_id), 32'd0);
    check("and_result", rsp_result, 32'h0000_000F);
    tick();
    check("mul_drain", 32'(rsp_valid), 32'd0);

    // ---- illegal and edge ops ----
    op0("illegal", 32'd5, 32'd3, 4'b0010, 32'd0, 1'b0, 1'b1);
    op0("sll33", 32'd1, 32'd33, 4'b0011, 32'h2, 1'b0, 1'b0);
    op0("slt", 32'hFFFF_FFFF, 32'd1, 4'b1000, 32'd0, 1'b1, 1'b0);
    op0("srl", 32'h8000_0000, 32'h0000_003F, 4'b0101, 32'h1, 1'b0, 1'b0);
    op0("sub_wrap", 32'd0, 32'd1, 4'b0100, 32'hFFFF_FFFF, 1'b0, 1'b0);
    op0("or", 32'h1200_0000, 32'h0000_0034, 4'b0001, 32'h1200_0034, 1'b0, 1'b0);
    tick();

    // ---- reset in the middle of a MUL ----
    drive0(32'd3, 32'd4, 4'b0110);
    tick();
    req0_valid = 1'b0;
    tick();
    check("rmul_wait_valid", 32'(rsp_valid), 32'd0);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check("rmul_state", 32'(dut.state), 32'd0);
    check("rmul_valid", 32'(rsp_valid), 32'd0);
    for (int i = 0; i < 5; i++) begin
      tick();
      check("rmul_no_stale", 32'(rsp_valid), 32'd0);
    end

    // ---- final report ----
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  // Absolute time guard: the directed sequence is a few hundred cycles.
  initial begin
    #100000;
    $display("FAIL timeout got=0x%08h exp=0x%08h", 32'd0, 32'd1);
    errors++;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
